dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port word-addressed data memory.
- Port A is the pipeline MEM stage; port B is a secondary master (loader/debug bridge).
- Grants one request at a time, round-robin, and performs byte-enable stores as read-merge-write.
- Returns read data with a fixed latency and flags out-of-range addresses.

Parameters:
- AW, 12, memory word-address width (memory word index = byte address bits [AW+1:2])
- DEPTH, 3072, number of implemented words; word index >= DEPTH is out of range

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A request valid
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  32  port A byte address; bits [1:0] ignored
- a_wdata  in  32  port A store data, byte lanes aligned to word
- a_be  in  4  port A byte enables (writes only; ignored on reads)
- a_ready  out  1  port A request accepted (1-cycle pulse)
- a_rvalid  out  1  port A response valid (1-cycle pulse)
- a_rdata  out  32  port A read data
- a_err  out  1  port A response error, valid with a_rvalid
- b_req, b_we, b_addr, b_wdata, b_be, b_ready, b_rvalid, b_rdata, b_err: same as port A, for port B
- mem_addr  out  AW  word address to memory
- mem_we  out  1  memory word write enable
- mem_wdata  out  32  memory write word
- mem_rdata  in  32  memory read word (combinational read of mem_addr)
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=A.
  - All ready/rvalid/err/mem_we = 0; rdata = 0; mem_addr = 0; mem_wdata = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each request occupies exactly 3 cycles. No overlap.
- IDLE:
  - If only one port requests, grant it.
  - If both request, grant the port rr_ptr points to.
  - On grant: pulse x_ready that cycle; latch we/addr/wdata/be and owner; set rr_ptr to the other port; go to ACCESS.
  - With no request, stay in IDLE.
- Requester handshake: hold req and its fields stable until ready. Fields are sampled only on the ready cycle.
- ACCESS:
  - mem_addr = latched word index.
  - Read: capture mem_rdata.
  - Write with in-range address:
    - mem_we = 1 for this cycle only.
    - mem_wdata byte i = be[i] ? wdata byte i : mem_rdata byte i.
  - be = 4'b0000 → mem_we stays 0 (no-op write, normal response).
  - Out of range (index >= DEPTH): mem_we = 0, set err flag, read data = 0.
  - Go to RESP.
- RESP:
  - Owner's x_rvalid = 1 for one cycle.
  - x_rdata = captured word (writes return the merged word; 0 on error).
  - x_err = error flag.
  - Go to IDLE.
- Latency: request accepted at cycle N → memory write at the edge ending cycle N+1 → rvalid in cycle N+2.
- Earliest next grant is cycle N+3.
- Outputs toward the non-owner port stay 0.
- x_rdata and x_err hold their value only while x_rvalid = 1; otherwise 0.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B…
- A lone requester is granted back-to-back regardless of rr_ptr.
- Same-cycle new request and completion: the new request is not accepted in RESP, only in the following IDLE.
- Reset mid-operation:
  - Immediately returns to IDLE and drops the in-flight request.
  - No write occurs if reset is asserted during ACCESS; no response is issued.
  - rr_ptr returns to A.
- Address bits above AW+1 are ignored for indexing but included in the range check (index computed from bits [AW+1:2]; any nonzero bit in [31:AW+2] → err).

Test Plan:
- Reset, then A read addr 0x00000010, memory word 4 = 0x12345678 → a_ready in cycle N, a_rvalid and a_rdata = 0x12345678 in cycle N+2, a_err = 0.
- A write addr 0x8, wdata 0xAABBCCDD, be = 4'b0101, prior word 0x11223344 → mem_we in cycle N+1 with mem_wdata 0x11BB33DD; a_rdata = 0x11BB33DD at rvalid.
- A and B requesting continuously from reset → grant order A, B, A, B; ready pulses spaced 3 cycles apart; each rvalid appears only on its own port.
- B write to byte address 0x3000 (index 3072 >= DEPTH) → mem_we never asserts; b_rvalid with b_err = 1 and b_rdata = 0.
- Assert reset in the ACCESS cycle of an A full-word write → mem_we = 0, no a_rvalid; busy = 0 and all outputs 0 immediately.
- A write with be = 0 to word 5 = 0xCAFEF00D → mem_we stays 0; a_rvalid with a_rdata = 0xCAFEF00D, a_err = 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and sequencer for the single-port,
// word-addressed data memory. Port A is the pipeline MEM stage, port B is a
// secondary master. Each request takes IDLE -> ACCESS -> RESP (3 cycles);
// partial stores are performed as a read-merge-write inside ACCESS.
module dm_arbiter #(
   parameter int AW    = 12,
   parameter int DEPTH = 3072
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          a_req,
   input  logic          a_we,
   input  logic [31:0]   a_addr,
   input  logic [31:0]   a_wdata,
   input  logic [3:0]    a_be,
   output logic          a_ready,
   output logic          a_rvalid,
   output logic [31:0]   a_rdata,
   output logic          a_err,

   input  logic          b_req,
   input  logic          b_we,
   input  logic [31:0]   b_addr,
   input  logic [31:0]   b_wdata,
   input  logic [3:0]    b_be,
   output logic          b_ready,
   output logic          b_rvalid,
   output logic [31:0]   b_rdata,
   output logic          b_err,

   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,

   output logic          busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   // Range check covers the whole byte address: the word index must be below
   // DEPTH and every bit above the index field must be zero.
   function automatic logic outOfRange(input logic [31:0] addr);
      logic [31:0] wordIdx;
      logic [31:0] upperBits;
      wordIdx   = addr >> 2;
      wordIdx   = wordIdx & ((32'd1 << AW) - 32'd1);
      upperBits = addr >> (AW + 2);
      return (upperBits != 32'd0) || (wordIdx >= 32'(DEPTH));
   endfunction

   // Byte-lane merge of new store data over the current memory word.
   function automatic logic [31:0] mergeBytes(input logic [31:0] newWord,
                                              input logic [31:0] oldWord,
                                              input logic [3:0]  byteEn);
      logic [31:0] merged;
      merged = oldWord;
      for (int unsigned i = 0; i < 4; i++) begin
         if (byteEn[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      return merged;
   endfunction

   logic [1:0]    state;
   logic          rrPtr;
   logic          owner;
   logic          latWe;
   logic [AW-1:0] latIdx;
   logic [31:0]   latWdata;
   logic [3:0]    latBe;
   logic          latOor;
   logic [31:0]   capData;
   logic          errFlag;

   logic          grantA;
   logic          grantB;
   logic          selWe;
   logic [31:0]   selAddr;
   logic [31:0]   selWdata;
   logic [3:0]    selBe;
   logic          selOor;
   logic [31:0]   mergedWord;
   logic          respValid;

   // Grant decision in IDLE; reset suppresses any acceptance so a request
   // presented while reset is high is never acknowledged.
   always_comb begin
      grantA = 1'b0;
      grantB = 1'b0;
      if ((state == IDLE) && !reset) begin
         if (a_req && b_req) begin
            grantA = (rrPtr == OWNER_A);
            grantB = (rrPtr == OWNER_B);
         end else begin
            grantA = a_req;
            grantB = b_req;
         end
      end
   end

   // Field mux toward the latch registers, selecting the granted port.
   always_comb begin
      selWe    = grantB ? b_we    : a_we;
      selAddr  = grantB ? b_addr  : a_addr;
      selWdata = grantB ? b_wdata : a_wdata;
      selBe    = grantB ? b_be    : a_be;
      selOor   = outOfRange(selAddr);
   end

   // Merged store word built from the latched data over the live memory read.
   always_comb begin
      mergedWord = mergeBytes(latWdata, mem_rdata, latBe);
   end

   // Sequencer state, round-robin pointer and per-request latches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rrPtr    <= OWNER_A;
         owner    <= OWNER_A;
         latWe    <= 1'b0;
         latIdx   <= '0;
         latWdata <= '0;
         latBe    <= '0;
         latOor   <= 1'b0;
         capData  <= '0;
         errFlag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grantA || grantB) begin
                  owner    <= grantB ? OWNER_B : OWNER_A;
                  rrPtr    <= grantB ? OWNER_A : OWNER_B;
                  latWe    <= selWe;
                  latIdx   <= selAddr[AW+1:2];
                  latWdata <= selWdata;
                  latBe    <= selBe;
                  latOor   <= selOor;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (latOor) begin
                  capData <= '0;
               end else if (latWe) begin
                  capData <= mergedWord;
               end else begin
                  capData <= mem_rdata;
               end
               errFlag <= latOor;
               state   <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Memory-side drive: only active during ACCESS, zero otherwise.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (state == ACCESS) begin
         mem_addr = latIdx;
         if (latWe && !latOor) begin
            mem_wdata = mergedWord;
            mem_we    = (latBe != 4'b0000);
         end
      end
   end

   // Requester-side outputs; response fields are zero outside rvalid.
   always_comb begin
      respValid = (state == RESP);
      a_ready   = grantA;
      b_ready   = grantB;
      a_rvalid  = respValid && (owner == OWNER_A);
      b_rvalid  = respValid && (owner == OWNER_B);
      a_rdata   = a_rvalid ? capData : '0;
      b_rdata   = b_rvalid ? capData : '0;
      a_err     = a_rvalid && errFlag;
      b_err     = b_rvalid && errFlag;
      busy      = (state != IDLE);
   end

endmodule
